// File: rtl/rz_frame_scheduler.sv
// Frame sequencer for a unipolar RZ LED line driver: fetches pixels from a
// synchronous frame buffer, chains them into the driver, then waits out the latch.
module rz_frame_scheduler #(
  parameter int DATA_WIDTH = 24,
  parameter int MAX_LEDS   = 64,
  parameter int ADDR_WIDTH = $clog2(MAX_LEDS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_rd,
  input  logic [DATA_WIDTH-1:0] fb_data,
  output logic [DATA_WIDTH-1:0] drv_data,
  output logic                  drv_enable,
  input  logic                  drv_ready,
  output logic [2:0]            dbg_state,
  output logic                  dbg_pending
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_PRESENT   = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_LATCH     = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_LEDS);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   index_q, index_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH:0]   pend_len_q, pend_len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  en_q, en_d;
  logic                  go;
  logic [ADDR_WIDTH:0]   go_len;
  logic [ADDR_WIDTH:0]   len_clamped;

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      len_q      <= '0;
      pend_q     <= 1'b0;
      pend_len_q <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
      pend_len_q <= pend_len_d;
      data_q     <= data_d;
      en_q       <= en_d;
    end
  end

  // Driver handshake: the driver samples drv_data/drv_enable on any edge with
  // drv_ready=1; enable=1 consumes the word, enable=0 starts its reset time.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    len_d      = len_q;
    pend_d     = pend_q;
    pend_len_d = pend_len_q;
    data_d     = data_q;
    en_d       = en_q;
    go         = 1'b0;
    go_len     = len_clamped;
    case (state_q)
      ST_IDLE:      go = start;
      ST_FETCH:     state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        data_d  = fb_data;
        en_d    = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (drv_ready) begin
          if (index_q == len_q - LEN_ONE) begin
            en_d    = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            index_d = index_q + LEN_ONE;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DRAIN:     if (drv_ready) state_d = ST_LATCH;
      ST_LATCH:     if (drv_ready) state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
        // A start arriving in the DONE cycle supersedes any older queued length.
        if (start) begin
          go = 1'b1;
        end else if (pend_q) begin
          go     = 1'b1;
          go_len = pend_len_q;
        end
      end
      default:      state_d = ST_IDLE;
    endcase

    if (start && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      pend_d     = 1'b1;
      pend_len_d = len_clamped;
    end

    if (go) begin
      len_d   = go_len;
      index_d = '0;
      state_d = (go_len == '0) ? ST_DONE : ST_FETCH;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign fb_rd       = (state_q == ST_FETCH);
  assign fb_addr     = index_q[ADDR_WIDTH-1:0];
  assign drv_data    = data_q;
  assign drv_enable  = en_q;
  assign dbg_state   = state_q;
  assign dbg_pending = pend_q;

endmodule

// File: tb/tb_rz_frame_scheduler.sv
// Bench for rz_frame_scheduler: frame-level model of expected words, reads,
// busy and done timing, plus a timed line-driver model and a frame-buffer RAM.
module tb_rz_frame_scheduler;
  localparam int DW = 24;
  localparam int ML = 64;
  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   length = '0;
  logic          busy, done, fb_rd, drv_enable;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data = '0;
  logic [DW-1:0] drv_data;
  logic          drv_ready = 1'b1;
  logic [2:0]    dbg_state;
  logic          dbg_pending;

  rz_frame_scheduler #(.DATA_WIDTH(DW), .MAX_LEDS(ML), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .length(length),
    .busy(busy), .done(done), .fb_addr(fb_addr), .fb_rd(fb_rd),
    .fb_data(fb_data), .drv_data(drv_data), .drv_enable(drv_enable),
    .drv_ready(drv_ready), .dbg_state(dbg_state), .dbg_pending(dbg_pending)
  );

  always #5 clock = ~clock;

  // ---------------- frame buffer RAM ----------------
  logic [DW-1:0] mem [ML];
  initial for (int i = 0; i < ML; i++) mem[i] = DW'(32'habcdef + i);
  always @(posedge clock) if (fb_rd) fb_data <= mem[fb_addr];

  // ---------------- counters / model state ----------------
  int total = 0, bad = 0;
  int cyc = 0, frames_out = 0;
  int frame_len_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int rd_addr = 0, reads = 0, reads_frame = 0, cons_frame = 0, idle_events = 0;
  int done_cnt = 0, done_cyc = 0, start_cyc = 0, en_cycles = 0;
  bit prev_reset = 1'b0, prev_done = 1'b0, prev_ready = 1'b0;
  bit hold3 = 1'b0;
  int w_cyc = 48, r_cyc = 20;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clamp_len(input int l);
    return (l > ML) ? ML : l;
  endfunction

  // ---------------- line driver model ----------------
  // Normal mode: a consumed word keeps ready low for w_cyc cycles; an
  // enable=0 edge right after data starts an r_cyc reset time; otherwise idles
  // with ready high. hold3 mode: ready high 3 cycles of every 8.
  initial begin : driver_model
    bit r_s, rdy_s, en_s, sent, h_prev;
    int cnt, ph;
    sent = 0; cnt = 0; ph = 0; h_prev = 0;
    forever begin
      @(posedge clock);
      r_s = reset; rdy_s = drv_ready; en_s = drv_enable;
      #1;
      if (r_s) begin
        drv_ready = 1'b1; cnt = 0; sent = 0;
      end else if (hold3) begin
        if (!h_prev) ph = 0;
        ph++;
        drv_ready = ((ph % 8) >= 3) && ((ph % 8) <= 5);
      end else if (h_prev) begin
        drv_ready = 1'b1; cnt = 0; sent = 0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) drv_ready = 1'b1;
      end else if (rdy_s) begin
        if (en_s) begin
          sent = 1; cnt = w_cyc - 1; drv_ready = 1'b0;
        end else if (sent) begin
          sent = 0; cnt = r_cyc - 1; drv_ready = 1'b0;
        end
      end
      h_prev = hold3;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin : compare
    int l;
    bit consume, idle_ev;
    cyc++;
    if (prev_reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fb_rd", fb_rd, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_drv_en", drv_enable, 0);
      chk("rst_drv_data", drv_data, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_pending", dbg_pending, 0);
    end
    if (reset) begin
      frames_out = 0; frame_len_q.delete(); exp_q.delete();
      rd_addr = 0; reads_frame = 0; cons_frame = 0; idle_events = 0;
    end else begin
      chk("busy", busy, (frames_out > 0) ? 1 : 0);
      if (prev_done && frames_out > 0 && frame_len_q.size() > 0 && frame_len_q[0] > 0)
        chk("restart_fetch", fb_rd, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (frame_len_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          l = frame_len_q.pop_front();
          chk("frame_words", cons_frame, l);
          chk("frame_reads", reads_frame, l);
          if (l > 0 && !hold3) chk("latch_events", idle_events, 2);
        end
        cons_frame = 0; reads_frame = 0; rd_addr = 0; idle_events = 0;
        frames_out--;
      end
      if (fb_rd) begin
        chk("fb_addr", fb_addr, rd_addr);
        rd_addr++; reads++; reads_frame++;
      end
      if (drv_enable) en_cycles++;
      consume = drv_ready && drv_enable && (!hold3 || !prev_ready);
      idle_ev = drv_ready && !drv_enable && (!hold3 || !prev_ready);
      if (consume) begin
        if (exp_q.size() == 0) begin
          chk("word_unexpected", drv_data, 0);
        end else begin
          chk("word", drv_data, exp_q.pop_front());
        end
        got_q.push_back(drv_data);
        if (cons_frame > 0 && !hold3) chk("no_gap", idle_events, 0);
        cons_frame++;
        idle_events = 0;
      end
      if (idle_ev) idle_events++;
      if (start) begin
        l = clamp_len(int'(length));
        frames_out++;
        frame_len_q.push_back(l);
        for (int i = 0; i < l; i++) exp_q.push_back(mem[i]);
        start_cyc = cyc;
        idle_events = 0;
      end
    end
    prev_reset = reset;
    prev_done  = done && !reset;
    prev_ready = drv_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic send(input int l);
    @(posedge clock); #2;
    start = 1'b1; length = (AW+1)'(l);
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clock);
    #2;
    if (done_cnt < target) chk({name, "_timeout"}, done_cnt, target);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(posedge clock);
    #2;
    if (got_q.size() < n) chk("got_timeout", got_q.size(), n);
  endtask

  initial begin : watchdog
    #5000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin : tests
    int d0, r0, e0;
    step(4);
    reset = 1'b0;
    step(2);

    // Four words at 1.2 us bit time / 80 us reset (100 MHz clock).
    w_cyc = 2880; r_cyc = 8000;
    got_q.delete(); d0 = done_cnt;
    send(4);
    wait_done(d0 + 1, 25000, "t1");
    chk("t1_latency", done_cyc - start_cyc, 19524);
    chk("t1_nwords", got_q.size(), 4);
    chk("t1_w0", got_q[0], 24'habcdef);
    chk("t1_w3", got_q[3], 24'habcdf2);
    step(3);
    chk("t1_busy_low", busy, 0);
    chk("t1_one_done", done_cnt - d0, 1);

    // Single word.
    w_cyc = 48; r_cyc = 20;
    r0 = reads; d0 = done_cnt;
    send(1);
    wait_done(d0 + 1, 500, "t2");
    chk("t2_latency", done_cyc - start_cyc, 72);
    chk("t2_reads", reads - r0, 1);

    // Empty frame.
    step(2);
    r0 = reads; e0 = en_cycles; d0 = done_cnt;
    send(0);
    wait_done(d0 + 1, 20, "t3");
    chk("t3_latency", done_cyc - start_cyc, 1);
    chk("t3_reads", reads - r0, 0);
    chk("t3_enable", en_cycles - e0, 0);

    // Second frame queued while the first is running.
    step(2);
    got_q.delete(); d0 = done_cnt;
    send(3);
    step(3);
    send(2);
    chk("t4_pending", dbg_pending, 1);
    wait_done(d0 + 2, 2000, "t4");
    chk("t4_two_done", done_cnt - d0, 2);
    chk("t4_nwords", got_q.size(), 5);
    chk("t4_f2_w0", got_q[3], 24'habcdef);
    step(3);
    chk("t4_busy_low", busy, 0);

    // Reset after the second word, then a clean frame.
    got_q.delete();
    send(4);
    wait_got(2, 500);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_enable", drv_enable, 0);
    chk("t5_state", dbg_state, 0);
    step(2);
    got_q.delete(); d0 = done_cnt;
    send(4);
    wait_done(d0 + 1, 1000, "t5");
    chk("t5_nwords", got_q.size(), 4);
    chk("t5_w3", got_q[3], 24'habcdf2);

    // Oversized length clamps to the buffer depth.
    step(2);
    got_q.delete(); r0 = reads; d0 = done_cnt;
    send(100);
    wait_done(d0 + 1, 5000, "t6");
    chk("t6_reads", reads - r0, 64);
    chk("t6_nwords", got_q.size(), 64);
    chk("t6_last", got_q[63], 24'habce2e);

    // Driver that holds ready high for three cycles per event.
    step(2);
    got_q.delete(); r0 = reads; d0 = done_cnt;
    @(posedge clock); #2;
    start = 1'b1; length = 7'd5; hold3 = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
    wait_done(d0 + 1, 300, "t7");
    chk("t7_reads", reads - r0, 5);
    chk("t7_nwords", got_q.size(), 5);
    chk("t7_w4", got_q[4], 24'habcdf3);
    step(2);
    hold3 = 1'b0;
    step(4);
    chk("t7_busy_low", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rz_frame_scheduler.md
Name: rz_frame_scheduler

Overview:
Sequences whole LED-strip frames through one unipolar_rz driver instance. It reads pixels in order from a synchronous frame-buffer RAM. It presents each pixel to the driver in time for back-to-back chaining, then lets the driver issue its reset/latch. It pulses done once the latch period completes. It sits between the pixel frame buffer and the unipolar_rz line driver.

Parameters:
DATA_WIDTH, 24, pixel width; must match the driver's DATA_WIDTH.
MAX_LEDS, 64, frame-buffer depth and maximum strip length.
ADDR_WIDTH, $clog2(MAX_LEDS), frame-buffer address width.

Ports:
clock  input  1  system clock, shared with the driver.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to send one frame.
length  input  ADDR_WIDTH+1  number of LEDs in the frame; sampled on the accepted start; valid range 0..MAX_LEDS.
busy  output  1  high from the accepted start until done.
done  output  1  single-cycle pulse when the frame is latched.
fb_addr  output  ADDR_WIDTH  frame-buffer read address.
fb_rd  output  1  read strobe; fb_data is valid on the cycle after fb_rd.
fb_data  input  DATA_WIDTH  frame-buffer read data.
drv_data  output  DATA_WIDTH  pixel to the driver.
drv_enable  output  1  driver enable.
drv_ready  input  1  driver ready.

Behaviour:
- Driver contract:
  - The driver samples drv_data and drv_enable on a clock edge where drv_ready=1.
  - drv_enable=1 at that edge consumes the word and chains it with no gap.
  - drv_enable=0 at that edge makes the driver emit its reset time. drv_ready rises again when the reset time ends.
- Reset values: busy=0, done=0, fb_rd=0, fb_addr=0, drv_enable=0, drv_data=0, state=IDLE, pending=0.
- States: IDLE, FETCH, WAIT_DATA, PRESENT, DRAIN, LATCH, DONE.
- IDLE:
  - start=1 with length>0: latch length, set index=0, busy=1, go to FETCH.
  - start=1 with length=0: go to DONE without touching the driver or RAM.
- FETCH: fb_rd=1 for one cycle with fb_addr=index, then go to WAIT_DATA.
- WAIT_DATA: register fb_data into drv_data, set drv_enable=1, go to PRESENT. Latency from start to drv_enable is 3 cycles.
- PRESENT:
  - Hold drv_data and drv_enable stable until an edge with drv_ready=1.
  - If index=length-1 at that edge: drv_enable<=0, go to DRAIN.
  - Otherwise: index<=index+1, go to FETCH. The next word is ready within 3 cycles, well before the driver's next ready (≥ DATA_WIDTH bit periods later), so chaining is never broken.
- DRAIN: drv_enable=0. The first drv_ready=1 edge puts the driver into its reset time; go to LATCH.
- LATCH: drv_enable=0. The next drv_ready=1 edge means the reset time has completed; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 on the following cycle, return to IDLE.
- If pending=1 on leaving DONE, clear it and behave as an accepted start in the same cycle, using the length value sampled when pending was set.
- start while busy:
  - Sets pending=1 and samples length. A later start overwrites the sampled length. At most one frame is queued.
  - start in the DONE cycle also queues.
- drv_ready may already be 1 on entry to PRESENT. In that case the word is consumed on the first PRESENT edge.
- drv_ready held continuously high is legal; each edge with ready=1 counts as one event.
- The index counter is ADDR_WIDTH+1 bits and never wraps. length>MAX_LEDS is clamped to MAX_LEDS.
- Reset mid-frame returns the block to reset values immediately; pending is cleared. The driver must be reset on the same reset net.
- drv_data is changed only in WAIT_DATA. No glitches may appear while drv_enable=1.

Test Plan:
- Drive start with length=4. RAM holds abcdef, abcdf0, abcdf1, abcdf2. Driver runs at 100 MHz with 1.2 us period and 80 us reset. Required: the line decodes the 4 words MSB-first with no reset gap between them. Exactly one done pulse arrives about 115.2 us + 80 us after start, and busy falls the cycle after done.
- Drive start with length=1 → one 24-bit word, then DRAIN, then LATCH. done arrives after the second ready edge following consumption. fb_rd is asserted exactly once.
- Drive start with length=0 → done pulses 1 cycle after start. fb_rd and drv_enable never assert.
- Drive a second start (length=2) during frame 1 (length=3) → frame 1 completes with done. Frame 2 begins in the same cycle as leaving DONE and sends 2 words; two done pulses total.
- Assert reset after the 2nd word is consumed → next cycle busy=0, drv_enable=0, state=IDLE. A subsequent start with length=4 sends all 4 words correctly.
- Use a bench driver model whose ready stays high for 3 cycles → each word is consumed only once per ready event. Check the RAM read count equals length.
